mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: 1/2/4/8-byte loads and stores against the dcache with byte enables,
// two-beat split of word-crossing accesses, load sign/zero extension and ALU pass-through.
module mem_access_unit #(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 64,
  parameter int SPLIT_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [2*XLEN-1:0]   in_alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   out_result,
  output logic                out_fault,
  output logic                dc_req,
  output logic                dc_we,
  output logic [ADDR_W-1:0]   dc_addr,
  output logic [XLEN/8-1:0]   dc_be,
  output logic [XLEN-1:0]     dc_wdata,
  input  logic [XLEN-1:0]     dc_rdata,
  input  logic                dc_done
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [2*XLEN-1:0]   out_result_q, out_result_d;
  logic                out_fault_q, out_fault_d;
  logic                dc_req_q, dc_req_d;
  logic                dc_we_q, dc_we_d;
  logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
  logic [BYTES-1:0]    dc_be_q, dc_be_d;
  logic [XLEN-1:0]     dc_wdata_q, dc_wdata_d;
  logic                is_load_q, is_load_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic                cross_q, cross_d;
  logic [2*XLEN-1:0]   alu_q, alu_d;
  logic [BYTES-1:0]    be_hi_q, be_hi_d;
  logic [XLEN-1:0]     wdata_hi_q, wdata_hi_d;
  logic [XLEN-1:0]     beat1_q, beat1_d;

  logic [OFFW-1:0]     in_off;
  logic [2*BYTES-1:0]  in_be_wide;
  logic [2*XLEN-1:0]   in_wd_wide;
  logic                in_cross;
  logic                in_fault;
  logic                in_mem;
  int                  in_n;
  logic [XLEN-1:0]     ld_b1, ld_b2, ld_raw;
  logic [2*XLEN-1:0]   cmp_result;

  // Keep the low n bytes of raw, filling the rest with the sign bit or zero.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                               input logic [1:0] size, input logic sgn);
    logic [XLEN-1:0] res;
    logic            msb;
    int              nb;
    res = raw;
    nb  = 1 << size;
    case (size)
      2'd0:    msb = raw[7];
      2'd1:    msb = raw[15];
      2'd2:    msb = raw[31];
      default: msb = raw[XLEN-1];
    endcase
    for (int b = 0; b < BYTES; b++) begin
      if (b >= nb) res[8*b +: 8] = {8{sgn & msb}};
      else         res[8*b +: 8] = raw[8*b +: 8];
    end
    return res;
  endfunction

  // Both beats' enables and data come from one double-width shift: low half is beat 1, high half beat 2.
  always_comb begin
    in_off     = in_addr[OFFW-1:0];
    in_n       = 1 << in_size;
    in_be_wide = '0;
    for (int b = 0; b < 2*BYTES; b++) in_be_wide[b] = (b < in_n);
    in_be_wide = in_be_wide << in_off;
    in_wd_wide = {{XLEN{1'b0}}, in_wdata} << (8 * int'(in_off));
    in_cross   = (int'(in_off) + in_n) > BYTES;
    in_fault   = (int'(in_size) > OFFW) || (in_cross && (SPLIT_EN == 0));
    in_mem     = (in_op == 2'd1) || (in_op == 2'd2);
  end

  always_comb begin
    ld_b1      = (state_q == BEAT2) ? beat1_q  : dc_rdata;
    ld_b2      = (state_q == BEAT2) ? dc_rdata : '0;
    ld_raw     = (ld_b1 >> (8 * int'(off_q))) | (ld_b2 << (8 * (BYTES - int'(off_q))));
    cmp_result = is_load_q ? {{XLEN{1'b0}}, load_ext(ld_raw, size_q, signed_q)} : alu_q;
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_fault_d  = out_fault_q;
    dc_req_d     = dc_req_q;
    dc_we_d      = dc_we_q;
    dc_addr_d    = dc_addr_q;
    dc_be_d      = dc_be_q;
    dc_wdata_d   = dc_wdata_q;
    is_load_d    = is_load_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    cross_d      = cross_q;
    alu_d        = alu_q;
    be_hi_d      = be_hi_q;
    wdata_hi_d   = wdata_hi_q;
    beat1_d      = beat1_q;

    if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
      out_result_d = '0;
      out_fault_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          is_load_d  = (in_op == 2'd1);
          size_d     = in_size;
          signed_d   = in_signed;
          off_d      = in_off;
          cross_d    = in_cross;
          alu_d      = in_alu_result;
          be_hi_d    = in_be_wide[2*BYTES-1:BYTES];
          wdata_hi_d = in_wd_wide[2*XLEN-1:XLEN];
          if (!in_mem) begin
            out_valid_d  = 1'b1;
            out_result_d = in_alu_result;
            out_fault_d  = 1'b0;
          end else if (in_fault) begin
            out_valid_d  = 1'b1;
            out_result_d = '0;
            out_fault_d  = 1'b1;
          end else begin
            state_d    = BEAT1;
            dc_req_d   = 1'b1;
            dc_we_d    = (in_op == 2'd2);
            dc_addr_d  = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            dc_be_d    = in_be_wide[BYTES-1:0];
            dc_wdata_d = in_wd_wide[XLEN-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      BEAT1: begin
        if (dc_done) begin
          beat1_d  = dc_rdata;
          dc_req_d = 1'b0;
          if (cross_q) begin
            state_d    = BEAT2;
            dc_addr_d  = dc_addr_q + ADDR_W'(BYTES);
            dc_be_d    = be_hi_q;
            dc_wdata_d = wdata_hi_q;
          end else begin
            state_d      = IDLE;
            out_valid_d  = 1'b1;
            out_result_d = cmp_result;
            out_fault_d  = 1'b0;
          end
        end else begin
          state_d = BEAT1;
        end
      end
      BEAT2: begin
        // First BEAT2 cycle is the mandatory request-low gap between beats.
        if (!dc_req_q) begin
          dc_req_d = 1'b1;
        end else if (dc_done) begin
          state_d      = IDLE;
          dc_req_d     = 1'b0;
          out_valid_d  = 1'b1;
          out_result_d = cmp_result;
          out_fault_d  = 1'b0;
        end else begin
          state_d = BEAT2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_fault_q  <= 1'b0;
      dc_req_q     <= 1'b0;
      dc_we_q      <= 1'b0;
      dc_addr_q    <= '0;
      dc_be_q      <= '0;
      dc_wdata_q   <= '0;
      is_load_q    <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      cross_q      <= 1'b0;
      alu_q        <= '0;
      be_hi_q      <= '0;
      wdata_hi_q   <= '0;
      beat1_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_fault_q  <= out_fault_d;
      dc_req_q     <= dc_req_d;
      dc_we_q      <= dc_we_d;
      dc_addr_q    <= dc_addr_d;
      dc_be_q      <= dc_be_d;
      dc_wdata_q   <= dc_wdata_d;
      is_load_q    <= is_load_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      cross_q      <= cross_d;
      alu_q        <= alu_d;
      be_hi_q      <= be_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      beat1_q      <= beat1_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_fault  = out_fault_q;
  assign dc_req     = dc_req_q;
  assign dc_we      = dc_we_q;
  assign dc_addr    = dc_addr_q;
  assign dc_be      = dc_be_q;
  assign dc_wdata   = dc_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: 64-bit split-enabled unit with a dcache responder, plus a 32-bit
// no-split unit for the fault paths.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [1:0]   in_op = 2'd0, in_size = 2'd0;
  logic [63:0]  in_addr = '0, in_wdata = '0;
  logic [127:0] in_alu_result = '0, out_result;
  logic         out_valid, out_ready = 1'b1, out_fault;
  logic         dc_req, dc_we, dc_done;
  logic [63:0]  dc_addr, dc_wdata, dc_rdata;
  logic [7:0]   dc_be;

  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_fault1, dc_req1, dc_we1;
  logic [1:0]   in_op1 = 2'd0, in_size1 = 2'd0;
  logic [31:0]  in_addr1 = '0, in_wdata1 = '0, dc_addr1, dc_wdata1;
  logic [63:0]  in_alu_result1 = '0, out_result1;
  logic [3:0]   dc_be1;

  mem_access_unit #(.XLEN(64), .ADDR_W(64), .SPLIT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_result(in_alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fault(out_fault), .dc_req(dc_req), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_be(dc_be), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_done(dc_done));

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1),
    .in_size(in_size1), .in_signed(1'b0), .in_addr(in_addr1), .in_wdata(in_wdata1),
    .in_alu_result(in_alu_result1), .out_valid(out_valid1), .out_ready(1'b1),
    .out_result(out_result1), .out_fault(out_fault1), .dc_req(dc_req1), .dc_we(dc_we1),
    .dc_addr(dc_addr1), .dc_be(dc_be1), .dc_wdata(dc_wdata1), .dc_rdata(32'h0), .dc_done(1'b0));

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        we;
    logic [63:0] rdata;
  } beat_t;

  beat_t        bq[$];
  logic [127:0] sb_res[$];
  logic         sb_flt[$];
  int           n_checks = 0, n_errors = 0;
  int           req_cycles = 0, wait_c = 0, inj_req = 0, inj_seen = 0, req_before = 0;
  logic         resp_en = 1'b1, prev_done = 1'b0;
  beat_t        rb;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_res(input logic [127:0] r, input logic f);
    sb_res.push_back(r);
    sb_flt.push_back(f);
  endtask

  task automatic exp_beat(input logic [63:0] a, input logic [7:0] be, input logic [63:0] wd,
                          input logic we, input logic [63:0] rd);
    beat_t b;
    b.addr = a; b.be = be; b.wdata = wd; b.we = we; b.rdata = rd;
    bq.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic [127:0] alu);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_size = size; in_signed = sgn;
    in_addr = addr; in_wdata = wdata; in_alu_result = alu;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check_eq("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'd0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_res.size() != 0 || bq.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_eq(tag, {127'd0, n < 100}, 128'd1);
  endtask

  task automatic u1_fault(input string tag, input logic [1:0] size, input logic [31:0] addr);
    check_eq({tag, "_rdy"}, {127'd0, in_ready1}, 128'd1);
    in_valid1 = 1'b1; in_op1 = 2'd1; in_size1 = size; in_addr1 = addr;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_op1 = 2'd0;
    @(negedge clk);
    check_eq({tag, "_valid"}, {127'd0, out_valid1}, 128'd1);
    check_eq({tag, "_fault"}, {127'd0, out_fault1}, 128'd1);
    check_eq({tag, "_result"}, {64'd0, out_result1}, 128'd0);
    @(posedge clk); #1;
  endtask

  // dcache model: answers each request after two request-high cycles, checking it against the beat queue.
  initial begin
    dc_done = 1'b0; dc_rdata = '0;
    forever begin
      @(negedge clk);
      dc_done = 1'b0;
      if (dc_req) req_cycles++;
      if (prev_done) check_eq("req_gap", {127'd0, dc_req}, 128'd0);
      prev_done = 1'b0;
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        dc_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        dc_done = 1'b1;
      end else if (resp_en && dc_req) begin
        wait_c++;
        if (wait_c == 2) begin
          wait_c = 0;
          if (bq.size() == 0) begin
            check_eq("beat_unexpected", 128'd1, 128'd0);
          end else begin
            rb = bq.pop_front();
            check_eq("dc_addr", {64'd0, dc_addr}, {64'd0, rb.addr});
            check_eq("dc_be", {120'd0, dc_be}, {120'd0, rb.be});
            check_eq("dc_wdata", {64'd0, dc_wdata}, {64'd0, rb.wdata});
            check_eq("dc_we", {127'd0, dc_we}, {127'd0, rb.we});
            dc_rdata = rb.rdata;
          end
          dc_done = 1'b1;
          prev_done = 1'b1;
        end
      end
    end
  end

  // Output monitor: every writeback handshake pops and compares one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        check_eq("req_low_at_result", {127'd0, dc_req}, 128'd0);
        if (out_ready) begin
          if (sb_res.size() == 0) begin
            check_eq("result_unexpected", 128'd1, 128'd0);
          end else begin
            check_eq("out_result", out_result, sb_res.pop_front());
            check_eq("out_fault", {127'd0, out_fault}, {127'd0, sb_flt.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check_eq("rst_outs", {out_valid, out_fault, dc_req, dc_we, dc_be}, 128'd0);
    check_eq("rst_result", out_result, 128'd0);
    check_eq("rst_addr_wdata", {dc_addr, dc_wdata}, 128'd0);
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    req_before = req_cycles;
    exp_res(128'h1234, 1'b0);
    send(2'd0, 2'd0, 1'b0, 64'h0, 64'h0, 128'h1234);
    @(negedge clk);
    check_eq("pt_latency", {127'd0, out_valid}, 128'd1);
    @(posedge clk); #1;
    wait_drain("pt_drain");
    check_eq("pt_no_req", req_cycles, req_before);

    exp_beat(64'h1000, 8'hF0, 64'h0, 1'b0, 64'h87654321_00000000);
    exp_res({64'h0, 64'hFFFFFFFF_87654321}, 1'b0);
    send(2'd1, 2'd2, 1'b1, 64'h1004, 64'h0, 128'h9);
    wait_drain("ld4s_drain");

    exp_beat(64'h1000, 8'hC0, 64'h7788000000000000, 1'b1, 64'h0);
    exp_beat(64'h1008, 8'h3F, 64'h0000112233445566, 1'b1, 64'h0);
    exp_res(128'h55, 1'b0);
    send(2'd2, 2'd3, 1'b0, 64'h1006, 64'h1122334455667788, 128'h55);
    wait_drain("st8_split_drain");

    exp_beat(64'h1008, 8'h80, 64'h0, 1'b0, 64'hAB00000000000000);
    exp_beat(64'h1010, 8'h01, 64'h0, 1'b0, 64'h00000000000000CD);
    exp_res(128'hCDAB, 1'b0);
    send(2'd1, 2'd1, 1'b0, 64'h100F, 64'h0, 128'h0);
    wait_drain("ld2u_split_drain");

    exp_beat(64'h1000, 8'h08, 64'h0, 1'b0, 64'h00000000_80000000);
    exp_res({64'h0, 64'hFFFFFFFF_FFFFFF80}, 1'b0);
    send(2'd1, 2'd0, 1'b1, 64'h1003, 64'h0, 128'h0);
    wait_drain("ld1s_drain");

    exp_beat(64'h1000, 8'h80, 64'h0, 1'b0, 64'hFE00000000000000);
    exp_beat(64'h1008, 8'h01, 64'h0, 1'b0, 64'h00000000000000FF);
    exp_res({64'h0, 64'hFFFFFFFF_FFFFFFFE}, 1'b0);
    send(2'd1, 2'd1, 1'b1, 64'h1007, 64'h0, 128'h0);
    wait_drain("ld2s_split_drain");

    exp_beat(64'h2000, 8'hFF, 64'h0, 1'b0, 64'h0123456789ABCDEF);
    exp_res(128'h0123456789ABCDEF, 1'b0);
    send(2'd1, 2'd3, 1'b0, 64'h2000, 64'h0, 128'h0);
    wait_drain("ld8_drain");

    exp_beat(64'h2000, 8'hF0, 64'h0, 1'b0, 64'h89ABCDEF_01234567);
    exp_res(128'h89ABCDEF, 1'b0);
    send(2'd1, 2'd2, 1'b0, 64'h2004, 64'h0, 128'h0);
    wait_drain("ld4u_drain");

    exp_beat(64'h1000, 8'h20, 64'h0000A50000000000, 1'b1, 64'h0);
    exp_res(128'h77, 1'b0);
    send(2'd2, 2'd0, 1'b0, 64'h1005, 64'hA5, 128'h77);
    wait_drain("st1_drain");

    exp_res(128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0);
    send(2'd3, 2'd3, 1'b0, 64'h1006, 64'h0, 128'hDEADBEEF_00000000_CAFEF00D_12345678);
    wait_drain("reserved_drain");

    out_ready = 1'b0;
    exp_res(128'hA1, 1'b0);
    exp_res(128'hB2, 1'b0);
    send(2'd0, 2'd0, 1'b0, 64'h0, 64'h0, 128'hA1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {127'd0, in_ready}, 128'd0);
      check_eq("bp_valid", {127'd0, out_valid}, 128'd1);
      check_eq("bp_hold", out_result, 128'hA1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd0, 2'd0, 1'b0, 64'h0, 64'h0, 128'hB2);
    check_eq("bp_one_pop", sb_res.size(), 1);
    wait_drain("bp_drain");

    resp_en = 1'b0;
    send(2'd1, 2'd3, 1'b0, 64'h3000, 64'h0, 128'h0);
    @(negedge clk);
    check_eq("rst_mid_req", {64'd0, dc_addr}, 128'h3000);
    check_eq("rst_mid_req_up", {127'd0, dc_req}, 128'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", {out_valid, out_fault, dc_req, dc_we, dc_be}, 128'd0);
    check_eq("rst_mid_addr_wdata", {dc_addr, dc_wdata}, 128'd0);
    check_eq("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    inj_req++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_late_done", {126'd0, out_valid, dc_req}, 128'd0);
    resp_en = 1'b1;
    @(posedge clk); #1;

    exp_res(128'h42, 1'b0);
    send(2'd0, 2'd1, 1'b0, 64'h0, 64'h0, 128'h42);
    wait_drain("post_rst_drain");

    u1_fault("ns_misaligned", 2'd2, 32'h1006);
    u1_fault("ns_oversize", 2'd3, 32'h1000);
    check_eq("ns_dc_quiet", {58'd0, dc_req1, dc_we1, dc_addr1, dc_be1, dc_wdata1}, 128'd0);

    check_eq("sb_empty", sb_res.size() + bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
